// File: rtl/reorder_buffer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : reorder_buffer_pkg
// Brief    : Shared sizing constants for the reorder buffer slice.
// Revision : 1.0 - initial release
// ============================================================================
package reorder_buffer_pkg;

    localparam int   c_rob_tag_w = 4;
    localparam int   c_rob_depth = 1 << c_rob_tag_w;
    localparam int   c_cdb_ports = 2;
    localparam int   c_data_w    = 32;
    localparam int   c_raddr_w   = 5;
    localparam logic c_true      = 1'b1;
    localparam logic c_false     = 1'b0;

endpackage : reorder_buffer_pkg
`default_nettype wire

// File: rtl/reorder_buffer_entry_array.sv
`default_nettype none
// ============================================================================
// Module   : reorder_buffer_entry_array
// Brief    : ROB entry storage, multi-port writeback and tag query/bypass.
// Revision : 1.0 - initial release
// ============================================================================
module reorder_buffer_entry_array
    import reorder_buffer_pkg::*;
#(
    parameter int TAG_W   = c_rob_tag_w,
    parameter int DATA_W  = c_data_w,
    parameter int RADDR_W = c_raddr_w,
    parameter int NWB     = c_cdb_ports
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_en,
    input  logic                    i_flush,
    input  logic                    i_disp_fire,
    input  logic [TAG_W-1:0]        i_disp_idx,
    input  logic                    i_disp_has_rd,
    input  logic [RADDR_W-1:0]      i_disp_rd,
    input  logic                    i_pop,
    input  logic [TAG_W-1:0]        i_head_idx,
    input  logic [NWB-1:0]          i_wb_valid,
    input  logic [NWB*TAG_W-1:0]    i_wb_tag,
    input  logic [NWB*DATA_W-1:0]   i_wb_value,
    input  logic [TAG_W-1:0]        i_qry_tag,
    output logic                    o_qry_done,
    output logic [DATA_W-1:0]       o_qry_value,
    output logic                    o_head_busy,
    output logic                    o_head_done,
    output logic                    o_head_has_rd,
    output logic [RADDR_W-1:0]      o_head_rd,
    output logic [DATA_W-1:0]       o_head_value
);

    localparam int DEPTH = 1 << TAG_W;

    logic [DEPTH-1:0]   r_busy;
    logic [DEPTH-1:0]   r_done;
    logic               r_has_rd [DEPTH];
    logic [RADDR_W-1:0] r_rd     [DEPTH];
    logic [DATA_W-1:0]  r_value  [DEPTH];

    logic [DEPTH-1:0]   w_wb_hit;
    logic [DATA_W-1:0]  w_wb_data [DEPTH];

    // Ascending port scan: the highest-index matching port overrides lower ones.
    always_comb begin
        for (int e = 0; e < DEPTH; e++) begin
            w_wb_hit[e]  = c_false;
            w_wb_data[e] = '0;
            for (int i = 0; i < NWB; i++) begin
                if (i_wb_valid[i] && (i_wb_tag[i*TAG_W +: TAG_W] == TAG_W'(e))) begin
                    w_wb_hit[e]  = c_true;
                    w_wb_data[e] = i_wb_value[i*DATA_W +: DATA_W];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_busy <= '0;
            r_done <= '0;
        end else if (i_en) begin
            if (i_flush) begin
                r_busy <= '0;
                r_done <= '0;
            end else begin
                for (int e = 0; e < DEPTH; e++) begin
                    if (i_disp_fire && (i_disp_idx == TAG_W'(e))) begin
                        r_busy[e] <= c_true;
                        r_done[e] <= c_false;
                    end else if (i_pop && (i_head_idx == TAG_W'(e))) begin
                        r_busy[e] <= c_false;
                        r_done[e] <= c_false;
                    end else if (r_busy[e] && w_wb_hit[e]) begin
                        r_done[e] <= c_true;
                    end
                end
            end
        end
    end

    // Payload fields need no reset; busy/done qualify them.
    always_ff @(posedge clk) begin
        if (i_en && !i_flush) begin
            for (int e = 0; e < DEPTH; e++) begin
                if (i_disp_fire && (i_disp_idx == TAG_W'(e))) begin
                    r_has_rd[e] <= i_disp_has_rd;
                    r_rd[e]     <= i_disp_rd;
                end else if (r_busy[e] && w_wb_hit[e]) begin
                    r_value[e]  <= w_wb_data[e];
                end
            end
        end
    end

    always_comb begin
        o_qry_done  = r_busy[i_qry_tag] && r_done[i_qry_tag];
        o_qry_value = r_value[i_qry_tag];
        for (int i = 0; i < NWB; i++) begin
            if (i_wb_valid[i] && (i_wb_tag[i*TAG_W +: TAG_W] == i_qry_tag)) begin
                o_qry_done  = c_true;
                o_qry_value = i_wb_value[i*DATA_W +: DATA_W];
            end
        end
    end

    assign o_head_busy   = r_busy[i_head_idx];
    assign o_head_done   = r_done[i_head_idx];
    assign o_head_has_rd = r_has_rd[i_head_idx];
    assign o_head_rd     = r_rd[i_head_idx];
    assign o_head_value  = r_value[i_head_idx];

endmodule : reorder_buffer_entry_array
`default_nettype wire

// File: rtl/reorder_buffer.sv
`default_nettype none
// ============================================================================
// Module   : reorder_buffer
// Brief    : Circular in-order-retire reorder buffer with multi-port writeback.
// Revision : 1.0 - initial release
// ============================================================================
module reorder_buffer
    import reorder_buffer_pkg::*;
#(
    parameter int TAG_W   = c_rob_tag_w,
    parameter int DATA_W  = c_data_w,
    parameter int RADDR_W = c_raddr_w,
    parameter int NWB     = c_cdb_ports
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    rdy,
    input  logic                    flush,
    input  logic                    disp_valid,
    input  logic                    disp_has_rd,
    input  logic [RADDR_W-1:0]      disp_rd,
    output logic                    disp_ready,
    output logic [TAG_W-1:0]        disp_tag,
    input  logic [NWB-1:0]          wb_valid,
    input  logic [NWB*TAG_W-1:0]    wb_tag,
    input  logic [NWB*DATA_W-1:0]   wb_value,
    input  logic [TAG_W-1:0]        qry_tag,
    output logic                    qry_done,
    output logic [DATA_W-1:0]       qry_value,
    output logic                    cmt_valid,
    input  logic                    cmt_ready,
    output logic                    cmt_has_rd,
    output logic [RADDR_W-1:0]      cmt_rd,
    output logic [DATA_W-1:0]       cmt_value,
    output logic [TAG_W-1:0]        cmt_tag,
    output logic [TAG_W:0]          rob_count,
    output logic                    rob_empty
);

    localparam int             DEPTH   = 1 << TAG_W;
    localparam logic [TAG_W:0] c_depth = (TAG_W+1)'(DEPTH);

    logic [TAG_W-1:0] r_head;
    logic [TAG_W-1:0] r_tail;
    logic [TAG_W:0]   r_count;

    logic w_disp_fire;
    logic w_cmt_fire;
    logic w_head_busy;
    logic w_head_done;

    // Full/empty come from count alone, so all DEPTH slots are usable.
    assign disp_ready  = (r_count < c_depth);
    assign disp_tag    = r_tail;
    assign cmt_valid   = w_head_busy && w_head_done;
    assign cmt_tag     = r_head;
    assign rob_count   = r_count;
    assign rob_empty   = (r_count == '0);

    assign w_disp_fire = disp_valid && disp_ready;
    assign w_cmt_fire  = cmt_valid && cmt_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (rdy) begin
            if (flush) begin
                r_head  <= '0;
                r_tail  <= '0;
                r_count <= '0;
            end else begin
                if (w_disp_fire) begin
                    r_tail <= r_tail + TAG_W'(1);
                end
                if (w_cmt_fire) begin
                    r_head <= r_head + TAG_W'(1);
                end
                r_count <= r_count + (TAG_W+1)'(w_disp_fire) - (TAG_W+1)'(w_cmt_fire);
            end
        end
    end

    reorder_buffer_entry_array #(
        .TAG_W   (TAG_W),
        .DATA_W  (DATA_W),
        .RADDR_W (RADDR_W),
        .NWB     (NWB)
    ) u_entry_array (
        .clk           (clk),
        .rst           (rst),
        .i_en          (rdy),
        .i_flush       (flush),
        .i_disp_fire   (w_disp_fire),
        .i_disp_idx    (r_tail),
        .i_disp_has_rd (disp_has_rd),
        .i_disp_rd     (disp_rd),
        .i_pop         (w_cmt_fire),
        .i_head_idx    (r_head),
        .i_wb_valid    (wb_valid),
        .i_wb_tag      (wb_tag),
        .i_wb_value    (wb_value),
        .i_qry_tag     (qry_tag),
        .o_qry_done    (qry_done),
        .o_qry_value   (qry_value),
        .o_head_busy   (w_head_busy),
        .o_head_done   (w_head_done),
        .o_head_has_rd (cmt_has_rd),
        .o_head_rd     (cmt_rd),
        .o_head_value  (cmt_value)
    );

endmodule : reorder_buffer
`default_nettype wire

// File: tb/tb_reorder_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_reorder_buffer
// Brief    : Self-checking bench for reorder_buffer against a queue-based model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_reorder_buffer;

    localparam int TAG_W   = 4;
    localparam int DEPTH   = 16;
    localparam int DATA_W  = 32;
    localparam int RADDR_W = 5;
    localparam int NWB     = 2;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  rdy;
    logic                  flush;
    logic                  disp_valid;
    logic                  disp_has_rd;
    logic [RADDR_W-1:0]    disp_rd;
    logic                  disp_ready;
    logic [TAG_W-1:0]      disp_tag;
    logic [NWB-1:0]        wb_valid;
    logic [NWB*TAG_W-1:0]  wb_tag;
    logic [NWB*DATA_W-1:0] wb_value;
    logic [TAG_W-1:0]      qry_tag;
    logic                  qry_done;
    logic [DATA_W-1:0]     qry_value;
    logic                  cmt_valid;
    logic                  cmt_ready;
    logic                  cmt_has_rd;
    logic [RADDR_W-1:0]    cmt_rd;
    logic [DATA_W-1:0]     cmt_value;
    logic [TAG_W-1:0]      cmt_tag;
    logic [TAG_W:0]        rob_count;
    logic                  rob_empty;

    reorder_buffer #(
        .TAG_W(TAG_W), .DATA_W(DATA_W), .RADDR_W(RADDR_W), .NWB(NWB)
    ) dut (
        .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
        .disp_valid(disp_valid), .disp_has_rd(disp_has_rd), .disp_rd(disp_rd),
        .disp_ready(disp_ready), .disp_tag(disp_tag),
        .wb_valid(wb_valid), .wb_tag(wb_tag), .wb_value(wb_value),
        .qry_tag(qry_tag), .qry_done(qry_done), .qry_value(qry_value),
        .cmt_valid(cmt_valid), .cmt_ready(cmt_ready), .cmt_has_rd(cmt_has_rd),
        .cmt_rd(cmt_rd), .cmt_value(cmt_value), .cmt_tag(cmt_tag),
        .rob_count(rob_count), .rob_empty(rob_empty)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model: program-order queue of in-flight instructions.
    typedef struct {
        logic [TAG_W-1:0]   tag;
        bit                 has_rd;
        logic [RADDR_W-1:0] rd;
        bit                 done;
        logic [DATA_W-1:0]  value;
    } ent_t;

    ent_t q[$];
    int   m_tail = 0;

    task automatic check_eq(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    // Entered just after a rising edge; drives one cycle, checks, advances model.
    task automatic cycle(input bit v_rdy, input bit v_flush, input bit v_disp, input bit v_has,
                         input logic [RADDR_W-1:0] v_rd, input logic [1:0] v_wbv,
                         input logic [TAG_W-1:0] t0, input logic [TAG_W-1:0] t1,
                         input logic [DATA_W-1:0] d0, input logic [DATA_W-1:0] d1,
                         input logic [TAG_W-1:0] qt, input bit v_cr);
        bit               exp_qd;
        logic [DATA_W-1:0] exp_qv;
        bit               exp_cv;
        bit               cfire;
        bit               dfire;
        rdy = v_rdy; flush = v_flush; disp_valid = v_disp; disp_has_rd = v_has; disp_rd = v_rd;
        wb_valid = v_wbv; wb_tag = {t1, t0}; wb_value = {d1, d0}; qry_tag = qt; cmt_ready = v_cr;
        #2;
        check_eq("rob_count", rob_count, q.size());
        check_eq("rob_empty", rob_empty, q.size() == 0);
        check_eq("disp_ready", disp_ready, q.size() < DEPTH);
        check_eq("disp_tag", disp_tag, m_tail);
        exp_cv = (q.size() > 0) && q[0].done;
        check_eq("cmt_valid", cmt_valid, exp_cv);
        if (exp_cv) begin
            check_eq("cmt_tag", cmt_tag, q[0].tag);
            check_eq("cmt_has_rd", cmt_has_rd, q[0].has_rd);
            check_eq("cmt_rd", cmt_rd, q[0].rd);
            check_eq("cmt_value", cmt_value, q[0].value);
        end
        exp_qd = 1'b0;
        exp_qv = '0;
        foreach (q[k]) begin
            if (q[k].tag == qt && q[k].done) begin
                exp_qd = 1'b1;
                exp_qv = q[k].value;
            end
        end
        if (v_wbv[0] && t0 == qt) begin exp_qd = 1'b1; exp_qv = d0; end
        if (v_wbv[1] && t1 == qt) begin exp_qd = 1'b1; exp_qv = d1; end
        check_eq("qry_done", qry_done, exp_qd);
        if (exp_qd) check_eq("qry_value", qry_value, exp_qv);

        if (v_rdy) begin
            if (v_flush) begin
                q.delete();
                m_tail = 0;
            end else begin
                cfire = exp_cv && v_cr;
                dfire = v_disp && (q.size() < DEPTH);
                foreach (q[k]) begin
                    if (v_wbv[0] && q[k].tag == t0) begin q[k].done = 1'b1; q[k].value = d0; end
                    if (v_wbv[1] && q[k].tag == t1) begin q[k].done = 1'b1; q[k].value = d1; end
                end
                if (cfire) void'(q.pop_front());
                if (dfire) begin
                    q.push_back('{tag: TAG_W'(m_tail), has_rd: v_has, rd: v_rd, done: 1'b0, value: '0});
                    m_tail = (m_tail + 1) % DEPTH;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input bit v_cr);
        cycle(1'b1, 1'b0, 1'b0, 1'b0, '0, 2'b00, '0, '0, '0, '0, '0, v_cr);
    endtask

    task automatic dispatch(input logic [RADDR_W-1:0] v_rd);
        cycle(1'b1, 1'b0, 1'b1, 1'b1, v_rd, 2'b00, '0, '0, '0, '0, '0, 1'b0);
    endtask

    initial begin
        logic [TAG_W-1:0]  t0, t1, qt;
        logic [1:0]        wbv;
        bit                cr;
        rst = 1'b1; rdy = 1'b1; flush = 1'b0; disp_valid = 1'b0; disp_has_rd = 1'b0;
        disp_rd = '0; wb_valid = '0; wb_tag = '0; wb_value = '0; qry_tag = '0; cmt_ready = 1'b0;
        #3;
        check_eq("reset_count", rob_count, 0);
        check_eq("reset_empty", rob_empty, 1);
        check_eq("reset_disp_ready", disp_ready, 1);
        check_eq("reset_cmt_valid", cmt_valid, 0);
        check_eq("reset_qry_done", qry_done, 0);
        #9 rst = 1'b0;
        @(posedge clk);
        #1;

        // Asynchronous reset in the middle of operation.
        dispatch(5'd1); dispatch(5'd2); dispatch(5'd3);
        #1 rst = 1'b1;
        disp_valid = 1'b0; wb_valid = '0;
        #1;
        check_eq("async_rst_count", rob_count, 0);
        check_eq("async_rst_empty", rob_empty, 1);
        check_eq("async_rst_cmt_valid", cmt_valid, 0);
        check_eq("async_rst_disp_tag", disp_tag, 0);
        #1 rst = 1'b0;
        q.delete();
        m_tail = 0;
        @(posedge clk);
        #1;

        // Out-of-order writeback, in-order commit.
        dispatch(5'd5); dispatch(5'd6); dispatch(5'd7);
        cycle(1'b1, 1'b0, 1'b0, 1'b0, '0, 2'b10, 4'd0, 4'd2, 32'h0, 32'h33, 4'd2, 1'b1);
        check_eq("ooo_no_commit_yet", cmt_valid, 0);
        cycle(1'b1, 1'b0, 1'b0, 1'b0, '0, 2'b01, 4'd0, 4'd0, 32'h11, 32'h0, 4'd0, 1'b1);
        check_eq("ooo_first_rd", cmt_rd, 5);
        check_eq("ooo_first_value", cmt_value, 32'h11);
        cycle(1'b1, 1'b0, 1'b0, 1'b0, '0, 2'b01, 4'd1, 4'd0, 32'h22, 32'h0, 4'd1, 1'b1);
        check_eq("ooo_second_rd", cmt_rd, 6);
        idle(1'b1);
        check_eq("ooo_third_value", cmt_value, 32'h33);
        idle(1'b1);
        check_eq("ooo_drained", rob_empty, 1);

        // Fill all 16 slots, then an ignored 17th dispatch.
        cycle(1'b1, 1'b1, 1'b0, 1'b0, '0, 2'b00, '0, '0, '0, '0, '0, 1'b0);
        for (int i = 0; i < DEPTH; i++) dispatch(RADDR_W'(i));
        check_eq("fill_disp_ready", disp_ready, 0);
        check_eq("fill_count", rob_count, 16);
        dispatch(5'd31);

        // Same-cycle writeback bypass onto the query port, then stored read.
        cycle(1'b1, 1'b0, 1'b0, 1'b0, '0, 2'b01, 4'd4, 4'd0, 32'hABCD, 32'h0, 4'd4, 1'b0);
        idle(1'b0);
        qry_tag = 4'd4;
        #1;
        check_eq("qry_stored_done", qry_done, 1);
        check_eq("qry_stored_value", qry_value, 32'hABCD);

        // Flush with a writeback pending in the same cycle.
        cycle(1'b1, 1'b1, 1'b1, 1'b1, 5'd9, 2'b11, 4'd0, 4'd1, 32'h5, 32'h6, 4'd0, 1'b1);
        check_eq("flush_count", rob_count, 0);
        for (int i = 0; i < 5; i++) dispatch(RADDR_W'(i + 10));
        cycle(1'b1, 1'b0, 1'b0, 1'b0, '0, 2'b01, 4'd0, 4'd0, 32'h77, 32'h0, 4'd3, 1'b0);
        for (int i = 0; i < 3; i++)
            cycle(1'b0, 1'b0, 1'b1, 1'b1, 5'd20, 2'b01, 4'd1, 4'd0, 32'h99, 32'h0, 4'd1, 1'b1);
        check_eq("rdy_low_count", rob_count, 5);

        // Randomised traffic, including wrap-around and full/empty boundaries.
        for (int n = 0; n < 3000; n++) begin
            for (int p = 0; p < NWB; p++) begin
                logic [TAG_W-1:0] t;
                if (q.size() > 0 && ($urandom % 4) != 0)
                    t = q[$urandom_range(q.size() - 1)].tag;
                else
                    t = TAG_W'($urandom);
                if (p == 0) t0 = t; else t1 = t;
            end
            wbv = 2'($urandom);
            qt  = (($urandom % 2) == 0) ? t0 : TAG_W'($urandom);
            cr  = ((n / 300) % 2 == 0) ? (($urandom % 4) != 0) : (($urandom % 4) == 0);
            cycle(($urandom % 10) != 0, ($urandom % 60) == 0, ($urandom % 3) != 0, 1'($urandom),
                  RADDR_W'($urandom), wbv, t0, t1, $urandom, $urandom, qt, cr);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_reorder_buffer
`default_nettype wire

// File: doc/reorder_buffer.md
Name: reorder_buffer

Overview:
Parametrised circular reorder buffer for the out-of-order core. It allocates tags at dispatch, accepts results from several writeback (CDB) ports in any order, and retires entries strictly in program order to the register file through a valid/ready commit handshake. It adds full-depth occupancy tracking, multi-port writeback, a tag query port for operand bypass, and a pipeline flush.

Parameters:
TAG_W, 4, tag/pointer width; DEPTH = 2**TAG_W entries
DATA_W, 32, result value width
RADDR_W, 5, architectural register index width
NWB, 2, number of writeback ports

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-high
rdy  in  1  global enable; low freezes all state
flush  in  1  discard all entries (mispredict/exception)
disp_valid  in  1  dispatch request
disp_has_rd  in  1  instruction writes a register
disp_rd  in  RADDR_W  destination register
disp_ready  out  1  entry available
disp_tag  out  TAG_W  tag assigned to this dispatch (= tail)
wb_valid  in  NWB  per-port result valid
wb_tag  in  NWB*TAG_W  per-port target tag, port i at [i*TAG_W +: TAG_W]
wb_value  in  NWB*DATA_W  per-port result
qry_tag  in  TAG_W  operand lookup tag
qry_done  out  1  queried entry has result
qry_value  out  DATA_W  queried entry result
cmt_valid  out  1  head entry ready to retire
cmt_ready  in  1  register file accepts commit
cmt_has_rd  out  1  head writes a register
cmt_rd  out  RADDR_W  head destination
cmt_value  out  DATA_W  head result
cmt_tag  out  TAG_W  head tag (lets the register file clear its rename only if tag matches)
rob_count  out  TAG_W+1  occupied entries
rob_empty  out  1  count == 0

Behaviour:
- State: head, tail (TAG_W bits, wrap modulo DEPTH), count (TAG_W+1 bits). Per entry: busy, done, has_rd, rd, value.
- Reset (async, rst high): head = tail = count = 0; all busy and done bits = 0. Outputs follow: disp_ready = 1, disp_tag = 0, cmt_valid = 0, qry_done = 0, rob_empty = 1, rob_count = 0. Values and rd fields are don't-care.
- rdy low: no state changes. Combinational outputs track frozen state.
- Priority per clock edge: rst > flush > normal operation.
- flush (rdy high): head = tail = count = 0; all busy and done bits cleared. Same-cycle dispatch, writeback and commit are ignored. Takes effect in one cycle.
- disp_ready = (count < DEPTH), combinational. All DEPTH entries are usable; there is no wasted slot.
- Dispatch fires on disp_valid && disp_ready. Entry[tail] gets busy = 1, done = 0, has_rd and rd captured; tail increments.
  - Commit in the same cycle does not make a full ROB accept dispatch; disp_ready depends only on registered count.
- Writeback: for each i with wb_valid[i], if entry[wb_tag[i]].busy, set done = 1 and value = wb_value[i]. A writeback to a non-busy tag is ignored.
  - Two ports targeting the same tag in one cycle is illegal; if it happens, the highest port index wins.
  - A writeback to the entry being dispatched in the same cycle is ignored.
- Commit: cmt_valid = busy[head] && done[head], combinational from registered state. cmt_* fields show entry[head].
  - Pop on cmt_valid && cmt_ready: busy[head] = 0, done[head] = 0, head increments.
  - A writeback to the head entry becomes committable the next cycle (minimum one-cycle writeback-to-commit latency).
  - At most one commit per cycle.
- count' = count + dispatch_fire - commit_fire. Simultaneous dispatch and commit leaves count unchanged.
- Query, combinational:
  - qry_done = 1 if a same-cycle wb_valid[i] has wb_tag[i] == qry_tag (bypass, highest matching port wins).
  - Otherwise qry_done = busy && done of entry[qry_tag].
  - qry_value is taken from the same source as qry_done.
- Wrap-around: head and tail roll from DEPTH-1 to 0 naturally. Full vs empty is resolved by count only.

Decomposition:
- Shared constants file (constants.v) gains `ROB_TAG_W, `ROB_DEPTH, `CDB_PORTS and the existing `True/`False.
- One natural sub-module, rob_entry_array: per-entry storage plus the NWB-way writeback write logic and the query read/bypass mux.
- Pointer, count, flush and commit control stay in reorder_buffer.

Test Plan:
- Reset mid-operation: dispatch 3 entries, assert rst asynchronously between edges -> immediately rob_count = 0, rob_empty = 1, cmt_valid = 0, disp_tag = 0.
- Fill: DEPTH = 16, dispatch 16 with cmt_ready = 0 -> disp_ready = 0 after the 16th. A 17th disp_valid is ignored. Tags issued are 0..15.
- Out-of-order writeback: dispatch tags 0, 1, 2 (rd = 5, 6, 7). wb port 1 writes tag 2 = 0x33, then port 0 writes tag 0 = 0x11, then tag 1 = 0x22 -> commits come out in order rd 5/0x11, 6/0x22, 7/0x33, one per cycle with cmt_ready = 1.
- Wrap and simultaneous: keep count = 15 while dispatching and committing every cycle for 40 cycles -> count stays 15, tags wrap 15 -> 0, commit order is preserved.
- Query bypass: entry 4 busy and not done. In the same cycle wb port 0 writes tag 4 = 0xABCD and qry_tag = 4 -> qry_done = 1, qry_value = 0xABCD. Next cycle the stored value is read.
- Flush and rdy: with 5 entries and a writeback pending, pulse flush -> next cycle count = 0 and the writeback is dropped. With rdy = 0, dispatch and commit have no effect for 3 cycles.
